// File: rtl/jtag_master_seq.sv
// JTAG master sequencer: TAP reset and IR/DR scans from Run-Test/Idle back to Run-Test/Idle.
// Define JTAG_MASTER_TDO_CAPTURE_EN to enable TDO capture into TDO_DATA (otherwise TDO_DATA is 0).
//   state    | meaning
//   S_IDLE   | waiting for START, TCK low, target in Run-Test/Idle
//   S_HDR    | TMS header walking RTI -> Shift-IR/DR
//   S_SHIFT  | LEN_M1+1 shift TCKs, TMS=1 on the last
//   S_TRL    | TMS 1,0: Update -> Run-Test/Idle
//   S_FIN    | one-cycle DONE pulse
//   S_RSTSEQ | TMS 1,1,1,1,1,0: Test-Logic-Reset -> Run-Test/Idle
module jtag_master_seq #(
    parameter int TCK_DIV = 2,
    parameter int DW      = 32
) (
    input  logic                  CLK,
    input  logic                  TRST,
    input  logic                  START,
    input  logic [1:0]            CMD,
    input  logic [$clog2(DW)-1:0] LEN_M1,
    input  logic [DW-1:0]         TDI_DATA,
    output logic                  BUSY,
    output logic                  DONE,
    output logic [DW-1:0]         TDO_DATA,
    output logic                  TCK,
    output logic                  TMS,
    output logic                  TDI,
    input  logic                  TDO
);

    localparam int LW = $clog2(DW);
    localparam int CW = (LW > 3) ? LW : 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_SHIFT,
        S_TRL,
        S_FIN,
        S_RSTSEQ
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      div_q, div_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            tck_q, tck_d;
    logic            tms_q, tms_d;
    logic            tdi_q, tdi_d;
    logic            ir_q, ir_d;
    logic [LW-1:0]   len_q, len_d;
    logic [DW-1:0]   data_q, data_d;
    logic            load;

`ifdef JTAG_MASTER_TDO_CAPTURE_EN
    logic [DW-1:0]   cap_q, cap_d;
    logic [DW-1:0]   tdo_q, tdo_d;
`else
    logic            unused_tdo;
    assign unused_tdo = TDO;
`endif

    // TMS level for TCK number c of the given phase
    function automatic logic tms_of(input state_t st, input logic [CW-1:0] c,
                                    input logic ir, input logic [LW-1:0] len);
        case (st)
            S_RSTSEQ: tms_of = (c < CW'(5));
            S_HDR:    tms_of = ir ? (c < CW'(2)) : (c == '0);
            S_SHIFT:  tms_of = (c == CW'(len));
            S_TRL:    tms_of = (c == '0);
            default:  tms_of = 1'b0;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        tck_d   = tck_q;
        tms_d   = tms_q;
        tdi_d   = tdi_q;
        ir_d    = ir_q;
        len_d   = len_q;
        data_d  = data_q;
        load    = 1'b0;
`ifdef JTAG_MASTER_TDO_CAPTURE_EN
        cap_d   = cap_q;
        tdo_d   = tdo_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (START) begin
                    ir_d   = (CMD == 2'b01);
                    len_d  = LEN_M1;
                    data_d = TDI_DATA;
                    cnt_d  = '0;
                    div_d  = '0;
                    load   = 1'b1;
`ifdef JTAG_MASTER_TDO_CAPTURE_EN
                    cap_d  = '0;
`endif
                    case (CMD)
                        2'b00:        state_d = S_RSTSEQ;
                        2'b01, 2'b10: state_d = S_HDR;
                        default:      state_d = S_FIN;
                    endcase
                end
            end
            S_FIN: state_d = S_IDLE;
            default: begin
                if (div_q != 8'(TCK_DIV - 1)) begin
                    div_d = div_q + 8'd1;
                end else begin
                    div_d = '0;
                    tck_d = ~tck_q;
                    if (!tck_q) begin
`ifdef JTAG_MASTER_TDO_CAPTURE_EN
                        if (state_q == S_SHIFT)
                            cap_d = cap_q | (DW'(TDO) << cnt_q);
`endif
                    end else begin
                        // falling TCK: move to the next TMS/TDI slot
                        load  = 1'b1;
                        cnt_d = cnt_q + CW'(1);
                        case (state_q)
                            S_RSTSEQ: if (cnt_q == CW'(5)) begin
                                state_d = S_FIN;
                                cnt_d   = '0;
                            end
                            S_HDR: if (cnt_q == (ir_q ? CW'(3) : CW'(2))) begin
                                state_d = S_SHIFT;
                                cnt_d   = '0;
                            end
                            S_SHIFT: if (cnt_q == CW'(len_q)) begin
                                state_d = S_TRL;
                                cnt_d   = '0;
                            end
                            S_TRL: if (cnt_q == CW'(1)) begin
                                state_d = S_FIN;
                                cnt_d   = '0;
`ifdef JTAG_MASTER_TDO_CAPTURE_EN
                                tdo_d   = cap_q;
`endif
                            end
                            default: ;
                        endcase
                    end
                end
            end
        endcase
        if (load) begin
            tms_d = tms_of(state_d, cnt_d, ir_d, len_d);
            tdi_d = (state_d == S_SHIFT) & (|(data_d & (DW'(1'b1) << cnt_d)));
        end
    end

    always_ff @(posedge CLK or posedge TRST) begin
        if (TRST) begin
            state_q <= S_RSTSEQ;
            div_q   <= '0;
            cnt_q   <= '0;
            tck_q   <= 1'b0;
            tms_q   <= 1'b1;
            tdi_q   <= 1'b0;
            ir_q    <= 1'b0;
            len_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            tck_q   <= tck_d;
            tms_q   <= tms_d;
            tdi_q   <= tdi_d;
            ir_q    <= ir_d;
            len_q   <= len_d;
            data_q  <= data_d;
        end
    end

`ifdef JTAG_MASTER_TDO_CAPTURE_EN
    always_ff @(posedge CLK or posedge TRST) begin
        if (TRST) begin
            cap_q <= '0;
            tdo_q <= '0;
        end else begin
            cap_q <= cap_d;
            tdo_q <= tdo_d;
        end
    end
    assign TDO_DATA = tdo_q;
`else
    assign TDO_DATA = '0;
`endif

    assign TCK  = tck_q;
    assign TMS  = tms_q;
    assign TDI  = tdi_q;
    assign BUSY = (state_q != S_IDLE);
    assign DONE = (state_q == S_FIN);

endmodule

// File: doc/jtag_master_seq.md
JTAG_MASTER_SEQ -- requirements
Module: jtag_master_seq

Interface
REQ-001 The block SHALL have parameter TCK_DIV, default 2: CLK cycles per TCK half-period, legal range 1..255.
REQ-002 The block SHALL have parameter DW, default 32: maximum scan length in bits and the width of the data buses.
REQ-003 The block SHALL have port CLK  input  1  system clock; all logic is on posedge CLK.
REQ-004 The block SHALL have port TRST  input  1  reset, asynchronous, active-high.
REQ-005 The block SHALL have port START  input  1  one-CLK command strobe, accepted only while BUSY=0.
REQ-006 The block SHALL have port CMD  input  2  command: 00=TAP reset, 01=IR scan, 10=DR scan, 11=reserved (no-op).
REQ-007 The block SHALL have port LEN_M1  input  $clog2(DW)  scan length minus 1 (1..DW bits).
REQ-008 The block SHALL have port TDI_DATA  input  DW  shift-in data, LSB shifted first.
REQ-009 The block SHALL have port BUSY  output  1  high from the CLK after START acceptance until DONE inclusive.
REQ-010 The block SHALL have port DONE  output  1  one-CLK pulse at command completion.
REQ-011 The block SHALL have port TDO_DATA  output  DW  captured TDO; the first captured bit is at bit 0; bits >= length are 0.
REQ-012 The block SHALL have ports TCK, TMS, TDI  output  1 each: JTAG drive to the target.
REQ-013 The block SHALL have port TDO  input  1  JTAG return from the target.

Function
REQ-014 The block SHALL keep TCK low when idle; each TCK period SHALL be a low phase of TCK_DIV CLKs followed by a high phase of TCK_DIV CLKs.
REQ-015 The block SHALL change TMS/TDI only on the CLK that drives TCK low, and SHALL sample TDO on the CLK that drives TCK high.
REQ-016 The block SHALL latch CMD, LEN_M1 and TDI_DATA at acceptance; input changes while BUSY=1 SHALL have no effect.
REQ-017 The block SHALL ignore START while BUSY=1; CMD=11 SHALL produce a DONE pulse with no TCK edges.
REQ-018 The state machine SHALL be IDLE -> HDR -> SHIFT -> TRL -> FIN -> IDLE for scans and IDLE -> RSTSEQ -> FIN -> IDLE for resets.
REQ-019 Every sequence SHALL start and end with the target in Run-Test/Idle.
REQ-020 The TMS sequence for a DR scan SHALL be HDR 1,0,0; SHIFT N bits with TMS=0 except the last bit TMS=1; TRL 1,0. This totals N+5 TCKs.
REQ-021 The TMS sequence for an IR scan SHALL be HDR 1,1,0,0; SHIFT as for DR; TRL 1,0. This totals N+6 TCKs.
REQ-022 The TMS sequence for a TAP reset SHALL be 1,1,1,1,1,0, totalling 6 TCKs; TDO_DATA SHALL be unchanged by a reset.
REQ-023 During SHIFT, bit i of TDI_DATA SHALL be presented on TDI for the i-th shift TCK; outside SHIFT, TDI SHALL be 0.
REQ-024 The TDO sample at shift TCK i SHALL be written to TDO_DATA[i]; TDO_DATA SHALL update only when DONE is asserted.
REQ-025 DONE SHALL assert one CLK after the final TCK falling edge (FIN state); the next START SHALL be accepted on the cycle after DONE.
REQ-026 The shift counter SHALL count from 0 to LEN_M1; LEN_M1=0 (1 bit) SHALL assert TMS=1 on the single shift TCK.
REQ-027 LEN_M1=DW-1 SHALL shift all DW bits with no wrap-around.

Reset
REQ-028 While TRST=1, the outputs SHALL be TCK=0, TMS=1, TDI=0, DONE=0, BUSY=1, TDO_DATA=0, and the state SHALL be RSTSEQ with counters cleared.
REQ-029 After TRST deassertion, the block SHALL run the 6-TCK reset sequence automatically, then pulse DONE and enter IDLE with BUSY=0.
REQ-030 TRST asserted mid-command SHALL abort the command immediately with no DONE pulse for it.

Configuration
REQ-031 With macro JTAG_MASTER_TDO_CAPTURE_EN defined, TDO sampling and TDO_DATA SHALL function as specified.
REQ-032 With JTAG_MASTER_TDO_CAPTURE_EN undefined, TDO SHALL be ignored and TDO_DATA SHALL be constant 0; all other timing SHALL be identical.

Verification
REQ-033 Release TRST, TCK_DIV=2 -> 6 TCK periods of 4 CLKs each with TMS 1,1,1,1,1,0; DONE pulses once; BUSY falls after DONE.
REQ-034 DR scan, LEN_M1=7, TDI_DATA=0xA5, TDO looped to TDI through a TAP model -> TMS 1,0,0,0x7,1,1,0 (13 TCKs); TDI bits 1,0,1,0,0,1,0,1; TDO_DATA=0xA5 at DONE.
REQ-035 IR scan, LEN_M1=5, TDI_DATA=0x09 against a TAP model -> 12 TCKs; model IR=0x09; model sees Update_IR then RTI; TMS low at end.
REQ-036 DR scan with LEN_M1=0 and with LEN_M1=31, TDI_DATA=0xDEADBEEF -> 6 and 37 TCKs respectively; 1-bit scan has TMS=1 on its only shift; 32-bit TDO_DATA=0xDEADBEEF.
REQ-037 Second START during BUSY, plus TRST pulse at shift bit 3 of a 16-bit DR -> second START ignored; abort with no DONE; auto reset sequence follows; TDO_DATA=0.
REQ-038 Build without JTAG_MASTER_TDO_CAPTURE_EN, rerun the REQ-034 scenario -> identical TCK/TMS/TDI waveforms; TDO_DATA=0x00.
